// File: rtl/cpu_pkg.sv
// Shared opcodes, FSM state encoding, ALU op codes and the control bundle
// that ctr drives into datapath.
package cpu_pkg;

  localparam logic [7:0] OP_LDA  = 8'h01;
  localparam logic [7:0] OP_STO  = 8'h02;
  localparam logic [7:0] OP_ADD  = 8'h03;
  localparam logic [7:0] OP_SUB  = 8'h04;
  localparam logic [7:0] OP_JMP  = 8'h05;
  localparam logic [7:0] OP_JEQ  = 8'h06;
  localparam logic [7:0] OP_HALT = 8'h07;

  typedef enum logic [2:0] {
    S_FETCH1,
    S_FETCH2,
    S_FETCH3,
    S_DECODE,
    S_EXEC1,
    S_EXEC2,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD      = 2'b00,
    ALU_SUB      = 2'b01,
    ALU_PASS_MDR = 2'b10,
    ALU_PASS_ACC = 2'b11
  } alu_op_t;

  typedef struct packed {
    logic    ld_mar;
    logic    mar_sel_ir;
    logic    ld_mdr;
    logic    ld_pc;
    logic    pc_sel_ir;
    logic    ld_ir;
    logic    ld_acc;
    alu_op_t alu_op;
  } ctrl_t;

endpackage

// File: rtl/ctr.sv
// Control FSM: sequences fetch/decode/execute and drives datapath loads
// and the memory write strobe. SUB decoding is gated by CPU_SUB_EN.
module ctr
  import cpu_pkg::*;
(
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] opcode_i,
  input  logic       zflag_i,
  output ctrl_t      ctrl_o,
  output logic       memrw_o
);

  state_t state_q, state_d;
  logic   mem_op;

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= S_FETCH1;
    else     state_q <= state_d;
  end

  always_comb begin
    mem_op = (opcode_i == OP_LDA) || (opcode_i == OP_STO) || (opcode_i == OP_ADD);
`ifdef CPU_SUB_EN
    if (opcode_i == OP_SUB) mem_op = 1'b1;
`endif
  end

  always_comb begin
    state_d       = state_q;
    ctrl_o        = '0;
    ctrl_o.alu_op = ALU_PASS_ACC;
    memrw_o       = 1'b0;
    case (state_q)
      S_FETCH1: begin
        ctrl_o.ld_mar = 1'b1;
        state_d       = S_FETCH2;
      end
      S_FETCH2: begin
        ctrl_o.ld_mdr = 1'b1;
        ctrl_o.ld_pc  = 1'b1;
        state_d       = S_FETCH3;
      end
      S_FETCH3: begin
        ctrl_o.ld_ir = 1'b1;
        state_d      = S_DECODE;
      end
      S_DECODE: begin
        if (mem_op) begin
          ctrl_o.ld_mar     = 1'b1;
          ctrl_o.mar_sel_ir = 1'b1;
          state_d           = S_EXEC1;
        end else if (opcode_i == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          if ((opcode_i == OP_JMP) || ((opcode_i == OP_JEQ) && zflag_i)) begin
            ctrl_o.ld_pc     = 1'b1;
            ctrl_o.pc_sel_ir = 1'b1;
          end
          state_d = S_FETCH1;
        end
      end
      S_EXEC1: begin
        if (opcode_i == OP_STO) begin
          // Strobe is masked by Rst so a reset edge never commits a write.
          memrw_o = ~Rst;
          state_d = S_FETCH1;
        end else begin
          ctrl_o.ld_mdr = 1'b1;
          state_d       = S_EXEC2;
        end
      end
      S_EXEC2: begin
        ctrl_o.ld_acc = 1'b1;
        if (opcode_i == OP_ADD) ctrl_o.alu_op = ALU_ADD;
`ifdef CPU_SUB_EN
        else if (opcode_i == OP_SUB) ctrl_o.alu_op = ALU_SUB;
`endif
        else ctrl_o.alu_op = ALU_PASS_MDR;
        state_d = S_FETCH1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH1;
    endcase
  end

endmodule

// File: rtl/datapath.sv
// Registers PC/MAR/IR/MDR/ACC, the ALU, address/PC muxes and the zero flag.
module datapath
  import cpu_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  ctrl_t       ctrl_i,
  input  logic [15:0] mem_q_i,
  output logic [7:0]  opcode_o,
  output logic        zflag_o,
  output logic [7:0]  mem_addr_o,
  output logic [15:0] mem_d_o
);

  logic [7:0]  pc_q, pc_d, mar_q, mar_d;
  logic [15:0] ir_q, ir_d, mdr_q, mdr_d, acc_q, acc_d;
  logic [15:0] alu_y;

  always_comb begin
    case (ctrl_i.alu_op)
      ALU_ADD:      alu_y = acc_q + mdr_q;
      ALU_SUB:      alu_y = acc_q - mdr_q;
      ALU_PASS_MDR: alu_y = mdr_q;
      default:      alu_y = acc_q;
    endcase
  end

  always_comb begin
    pc_d  = pc_q;
    mar_d = mar_q;
    ir_d  = ir_q;
    mdr_d = mdr_q;
    acc_d = acc_q;
    if (ctrl_i.ld_pc)  pc_d  = ctrl_i.pc_sel_ir ? ir_q[7:0] : pc_q + 8'd1;
    if (ctrl_i.ld_mar) mar_d = ctrl_i.mar_sel_ir ? ir_q[7:0] : pc_q;
    if (ctrl_i.ld_ir)  ir_d  = mdr_q;
    if (ctrl_i.ld_mdr) mdr_d = mem_q_i;
    if (ctrl_i.ld_acc) acc_d = alu_y;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      pc_q  <= '0;
      mar_q <= '0;
      ir_q  <= '0;
      mdr_q <= '0;
      acc_q <= '0;
    end else begin
      pc_q  <= pc_d;
      mar_q <= mar_d;
      ir_q  <= ir_d;
      mdr_q <= mdr_d;
      acc_q <= acc_d;
    end
  end

  assign opcode_o   = ir_q[15:8];
  assign zflag_o    = (acc_q == 16'h0000);
  assign mem_addr_o = mar_q;
  assign mem_d_o    = acc_q;

endmodule

// File: rtl/ram.sv
// 256 x 16 memory: combinational read, synchronous write. Not touched by reset.
module ram (
  input  logic        Clk,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [15:0] d_i,
  output logic [15:0] q_o
);

  logic [15:0] memory [0:255];

  always_ff @(posedge Clk) begin
    if (we_i) memory[addr_i] <= d_i;
  end

  assign q_o = memory[addr_i];

endmodule

// File: rtl/proj1_cpu.sv
// Accumulator CPU top: ctr + datapath + ram. Define CPU_SUB_EN to enable
// the SUB opcode (otherwise 0x04 executes as NOP).
module proj1_cpu
  import cpu_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  output logic        MemRW_IO,
  output logic [7:0]  MemAddr_IO,
  output logic [15:0] MemD_IO
);

  ctrl_t       ctrl;
  logic [7:0]  opcode;
  logic        zflag;
  logic [15:0] mem_q;

  ctr ctr_ins (
    .Clk      (Clk),
    .Rst      (Rst),
    .opcode_i (opcode),
    .zflag_i  (zflag),
    .ctrl_o   (ctrl),
    .memrw_o  (MemRW_IO)
  );

  datapath dp_ins (
    .Clk        (Clk),
    .Rst        (Rst),
    .ctrl_i     (ctrl),
    .mem_q_i    (mem_q),
    .opcode_o   (opcode),
    .zflag_o    (zflag),
    .mem_addr_o (MemAddr_IO),
    .mem_d_o    (MemD_IO)
  );

  ram ram_ins (
    .Clk    (Clk),
    .we_i   (MemRW_IO),
    .addr_i (MemAddr_IO),
    .d_i    (MemD_IO),
    .q_o    (mem_q)
  );

endmodule

// File: tb/tb_proj1_cpu.sv
// Directed bench for proj1_cpu: programs are preloaded into ram_ins.memory
// while reset is held, then run for a fixed number of cycles.
module tb_proj1_cpu;
  import cpu_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        MemRW_IO;
  logic [7:0]  MemAddr_IO;
  logic [15:0] MemD_IO;

  int unsigned checks = 0;
  int unsigned errors = 0;

  proj1_cpu dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .MemRW_IO   (MemRW_IO),
    .MemAddr_IO (MemAddr_IO),
    .MemD_IO    (MemD_IO)
  );

  always #5 Clk = ~Clk;

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int unsigned i = 0; i < 256; i++) dut.ram_ins.memory[8'(i)] = 16'h0000;
  endtask

  task automatic poke(input logic [7:0] a, input logic [15:0] d);
    dut.ram_ins.memory[a] = d;
  endtask

  function automatic logic [15:0] st();
    return 16'(dut.ctr_ins.state_q);
  endfunction

  function automatic logic [15:0] pc();
    return 16'(dut.dp_ins.pc_q);
  endfunction

  initial begin
    // ---- Program 1: LDA 0C / ADD 0D / STO 0E / HALT ----
    Rst = 1'b1;
    clear_mem();
    poke(8'h00, 16'h010C);
    poke(8'h01, 16'h030D);
    poke(8'h02, 16'h020E);
    poke(8'h03, 16'h0700);
    poke(8'h0C, 16'h0005);
    poke(8'h0D, 16'h0007);
    tick(2);
    chk("rst_state", st(), 16'(S_FETCH1));
    chk("rst_pc", pc(), 16'h0000);
    chk("rst_acc", dut.dp_ins.acc_q, 16'h0000);
    chk("rst_ir", dut.dp_ins.ir_q, 16'h0000);
    chk("rst_memrw", 16'(MemRW_IO), 16'h0000);
    chk("rst_addr", 16'(MemAddr_IO), 16'h0000);
    chk("rst_memd", MemD_IO, 16'h0000);
    Rst = 1'b0;
    tick(1);
    chk("f1_state", st(), 16'(S_FETCH2));
    chk("f1_mar", 16'(MemAddr_IO), 16'h0000);
    tick(1);
    chk("f2_pc", pc(), 16'h0001);
    chk("f2_mdr", dut.dp_ins.mdr_q, 16'h010C);
    tick(4);
    chk("lda_acc", dut.dp_ins.acc_q, 16'h0005);
    chk("lda_done_state", st(), 16'(S_FETCH1));
    tick(6);
    chk("add_acc", dut.dp_ins.acc_q, 16'h000C);
    tick(4);
    chk("sto_state", st(), 16'(S_EXEC1));
    chk("sto_memrw", 16'(MemRW_IO), 16'h0001);
    chk("sto_addr", 16'(MemAddr_IO), 16'h000E);
    chk("sto_memd", MemD_IO, 16'h000C);
    tick(1);
    chk("sto_strobe_1cyc", 16'(MemRW_IO), 16'h0000);
    chk("sto_m0e", dut.ram_ins.memory[8'h0E], 16'h000C);
    tick(26);
    chk("p1_halt", st(), 16'(S_HALT));
    chk("p1_m0e", dut.ram_ins.memory[8'h0E], 16'h000C);
    chk("p1_pc", pc(), 16'h0004);
    chk("p1_halt_memrw", 16'(MemRW_IO), 16'h0000);

    // ---- Program 2: LDA 0C / SUB 0D / STO 0E / HALT ----
    Rst = 1'b1;
    clear_mem();
    poke(8'h00, 16'h010C);
    poke(8'h01, 16'h040D);
    poke(8'h02, 16'h020E);
    poke(8'h03, 16'h0700);
    poke(8'h0C, 16'h0003);
    poke(8'h0D, 16'h0005);
    tick(2);
    Rst = 1'b0;
    tick(6);
    chk("p2_lda_acc", dut.dp_ins.acc_q, 16'h0003);
`ifdef CPU_SUB_EN
    tick(6);
    chk("p2_sub_acc", dut.dp_ins.acc_q, 16'hFFFE);
    tick(24);
    chk("p2_m0e", dut.ram_ins.memory[8'h0E], 16'hFFFE);
`else
    tick(4);
    chk("p2_nop_4cyc", st(), 16'(S_FETCH1));
    chk("p2_nop_pc", pc(), 16'h0002);
    chk("p2_nop_acc", dut.dp_ins.acc_q, 16'h0003);
    tick(26);
    chk("p2_m0e", dut.ram_ins.memory[8'h0E], 16'h0003);
`endif
    chk("p2_halt", st(), 16'(S_HALT));

    // ---- Program 3a: LDA zero / JEQ 10 taken / STO 0E ----
    Rst = 1'b1;
    clear_mem();
    poke(8'h00, 16'h010C);
    poke(8'h01, 16'h0610);
    poke(8'h02, 16'h0700);
    poke(8'h10, 16'h020E);
    poke(8'h11, 16'h0700);
    poke(8'h0C, 16'h0000);
    poke(8'h0E, 16'hBEEF);
    tick(2);
    Rst = 1'b0;
    tick(10);
    chk("p3a_jeq_pc", pc(), 16'h0010);
    tick(20);
    chk("p3a_m0e", dut.ram_ins.memory[8'h0E], 16'h0000);
    chk("p3a_pc", pc(), 16'h0012);
    chk("p3a_halt", st(), 16'(S_HALT));

    // ---- Program 3b: nonzero word, JEQ falls through ----
    Rst = 1'b1;
    poke(8'h0C, 16'h0009);
    poke(8'h0E, 16'hBEEF);
    tick(2);
    Rst = 1'b0;
    tick(10);
    chk("p3b_jeq_pc", pc(), 16'h0002);
    tick(20);
    chk("p3b_m0e", dut.ram_ins.memory[8'h0E], 16'hBEEF);
    chk("p3b_pc", pc(), 16'h0003);
    chk("p3b_halt", st(), 16'(S_HALT));

    // ---- Program 4: JMP FF, NOP at FF, PC wraps to 00 ----
    Rst = 1'b1;
    clear_mem();
    poke(8'h00, 16'h05FF);
    poke(8'hFF, 16'h0000);
    tick(2);
    Rst = 1'b0;
    tick(4);
    chk("p4_jmp_pc", pc(), 16'h00FF);
    chk("p4_jmp_4cyc", st(), 16'(S_FETCH1));
    // JMP has been fetched; make the word after the wrap a HALT.
    poke(8'h00, 16'h0700);
    tick(2);
    chk("p4_wrap_pc", pc(), 16'h0000);
    tick(6);
    chk("p4_halt", st(), 16'(S_HALT));
    chk("p4_pc", pc(), 16'h0001);

    // ---- Program 5: reset during EXEC1 of STO ----
    Rst = 1'b1;
    clear_mem();
    poke(8'h00, 16'h010C);
    poke(8'h01, 16'h020E);
    poke(8'h02, 16'h0700);
    poke(8'h0C, 16'h1234);
    poke(8'h0E, 16'h5555);
    tick(2);
    Rst = 1'b0;
    tick(10);
    chk("p5_exec1", st(), 16'(S_EXEC1));
    chk("p5_memrw_pre", 16'(MemRW_IO), 16'h0001);
    Rst = 1'b1;
    #1;
    chk("p5_memrw_masked", 16'(MemRW_IO), 16'h0000);
    tick(1);
    chk("p5_nowrite", dut.ram_ins.memory[8'h0E], 16'h5555);
    chk("p5_pc", pc(), 16'h0000);
    chk("p5_state", st(), 16'(S_FETCH1));
    chk("p5_acc", dut.dp_ins.acc_q, 16'h0000);
    chk("p5_addr", 16'(MemAddr_IO), 16'h0000);
    Rst = 1'b0;
    tick(2);
    chk("p5_restart_pc", pc(), 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
